// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: MD op codes and FSM state encodings.
package md_sequencer_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MULT_RUN = 2'd1;
   localparam logic [1:0] ST_DIV_RUN  = 2'd2;

   // Counter width able to hold n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/md_sequencer_calc.sv
// Combinational MD result: 64-bit product or quotient/remainder, holding HI/LO on divide by zero.
module md_calc
   import md_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic signed [2*WIDTH-1:0] a_ext;
   logic signed [2*WIDTH-1:0] b_ext;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic             sgn_div;
   logic             neg_q;
   logic             neg_r;
   logic             div_zero;

   always_comb begin
      if (md_op == MD_MULT) begin
         a_ext = $signed({{WIDTH{a[WIDTH-1]}}, a});
         b_ext = $signed({{WIDTH{b[WIDTH-1]}}, b});
      end else begin
         a_ext = $signed({{WIDTH{1'b0}}, a});
         b_ext = $signed({{WIDTH{1'b0}}, b});
      end
      prod = a_ext * b_ext;

      // Signed divide works on magnitudes so MIN / -1 needs no special case.
      sgn_div  = (md_op == MD_DIV);
      div_zero = (b == '0);
      a_mag    = (sgn_div && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
      b_mag    = (sgn_div && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
      q_mag    = div_zero ? '0 : (a_mag / b_mag);
      r_mag    = div_zero ? '0 : (a_mag % b_mag);
      neg_q    = sgn_div & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    = sgn_div & a[WIDTH-1];

      res_hi = hi;
      res_lo = lo;
      case (md_op)
         MD_MULT, MD_MULTU: begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
         end
         MD_DIV, MD_DIVU: begin
            if (!div_zero) begin
               res_lo = neg_q ? (WIDTH'(0) - q_mag) : q_mag;
               res_hi = neg_r ? (WIDTH'(0) - r_mag) : r_mag;
            end
         end
         default: begin
            res_hi = hi;
            res_lo = lo;
         end
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: accepts one op per start, models fixed latency, owns HI/LO.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic             req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = cnt_width(MAX_CYCLES);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] pend_hi;
   logic [WIDTH-1:0] pend_lo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             accept;

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .md_op  (md_op),
      .a      (a),
      .b      (b),
      .hi     (hi),
      .lo     (lo),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   // A flush in the same cycle discards the op; starts while running are dropped.
   assign accept = start & ~req & (state == ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (md_op)
                     MD_MULT, MD_MULTU: begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        cnt     <= MULT_LOAD;
                        state   <= ST_MULT_RUN;
                        busy    <= 1'b1;
                     end
                     MD_DIV, MD_DIVU: begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        cnt     <= DIV_LOAD;
                        state   <= ST_DIV_RUN;
                        busy    <= 1'b1;
                     end
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
               // Results land on the same edge busy drops, so they are visible together.
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  hi    <= pend_hi;
                  lo    <= pend_lo;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
